// File: rtl/uart_receiver.sv
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver with mid-bit sampling, ready/valid output,
//               frame-error and overrun pulses.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_receiver #(
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] divisor,
    input  logic        rx,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t                   state_q;
    logic [23:0]              cnt_q;
    logic [23:0]              div_q;
    logic [2:0]               bit_q;
    logic [7:0]               shift_q;
    logic [7:0]               shift_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     rx_s;
    logic [23:0]              half_cnt;
    logic [7:0]               data_out_q;
    logic                     data_valid_q;
    logic                     frame_err_q;
    logic                     overrun_q;
    logic                     busy_q;

    // Flops reset to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign half_cnt = div_q >> 1;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shift_d = {shift_q[6:0], rx_s};
        end else begin : g_lsb_first
            assign shift_d = {rx_s, shift_q[7:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 24'd0;
            div_q        <= 24'd0;
            bit_q        <= 3'd0;
            shift_q      <= 8'd0;
            data_out_q   <= 8'd0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            // Acceptance; a same-cycle delivery below overrides this clear.
            if (data_valid_q && data_ready) begin
                data_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= 24'd0;
                        div_q   <= divisor;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt_q == half_cnt) begin
                        cnt_q <= 24'd0;
                        bit_q <= 3'd0;
                        if (!rx_s) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end

                DATA: begin
                    if (cnt_q == div_q) begin
                        shift_q <= shift_d;
                        cnt_q   <= 24'd0;
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end

                STOP: begin
                    if (cnt_q == div_q) begin
                        cnt_q <= 24'd0;
                        if (rx_s) begin
                            if (!data_valid_q || data_ready) begin
                                data_out_q   <= shift_q;
                                data_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end

                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module      : tb_uart_receiver
// Description : Directed self-checking bench for uart_receiver.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] divisor;
    logic        rx;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    always #5 clk = ~clk;

    uart_receiver #(
        .MSB_FIRST   (1),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .divisor    (divisor),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Passive monitor, sampled on the falling edge.
    int         cyc       = 0;
    int         dv_rises  = 0;
    int         dv_cyc    = 0;
    int         fe_cyc    = 0;
    int         ov_cyc    = 0;
    int         busy_cyc  = 0;
    int         last_rise = 0;
    int         last_ov   = 0;
    logic       prev_dv   = 1'b0;
    logic [7:0] bytes_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) dv_cyc <= dv_cyc + 1;
        if (data_valid && !prev_dv) begin
            dv_rises  <= dv_rises + 1;
            last_rise <= cyc;
            bytes_q.push_back(data_out);
        end
        prev_dv <= data_valid;
        if (frame_err) fe_cyc <= fe_cyc + 1;
        if (overrun) begin
            ov_cyc  <= ov_cyc + 1;
            last_ov <= cyc;
        end
        if (busy) busy_cyc <= busy_cyc + 1;
    end

    int b_rises, b_dv, b_fe, b_ov, b_busy, b_bytes, c0;

    task automatic snap();
        b_rises = dv_rises;
        b_dv    = dv_cyc;
        b_fe    = fe_cyc;
        b_ov    = ov_cyc;
        b_busy  = busy_cyc;
        b_bytes = bytes_q.size();
        c0      = cyc;
    endtask

    function automatic logic [8:0] byte_at(input int i);
        if (i < bytes_q.size()) return {1'b0, bytes_q[i]};
        return 9'h1FF;
    endfunction

    task automatic drive_bit(input logic b, input int p);
        rx = b;
        repeat (p) @(negedge clk);
    endtask

    // Transmitter order: bit 7 first.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int p);
        logic [7:0] v;
        v = d;
        drive_bit(1'b0, p);
        for (int i = 7; i >= 0; i--) drive_bit(v[i], p);
        drive_bit(stop, p);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_data_out"},   {24'd0, data_out}, 32'h0);
        check({pfx, "_data_valid"}, {31'd0, data_valid}, 32'h0);
        check({pfx, "_frame_err"},  {31'd0, frame_err}, 32'h0);
        check({pfx, "_overrun"},    {31'd0, overrun}, 32'h0);
        check({pfx, "_busy"},       {31'd0, busy}, 32'h0);
    endtask

    initial begin
        logic [7:0] partial;
        rst_n      = 1'b0;
        rx         = 1'b1;
        divisor    = 24'd3;
        data_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xA5 at 4 clk/bit; delivery 2 sync + 1 + half + 1 + 9P cycles after the edge
        snap();
        send_frame(8'hA5, 1'b1, 4);
        repeat (20) @(negedge clk);
        check("a5_count",   dv_rises - b_rises, 1);
        check("a5_byte",    {23'd0, byte_at(b_bytes)}, 32'h0A5);
        check("a5_dv_width", dv_cyc - b_dv, 1);
        check("a5_latency", last_rise - c0, 41);
        check("a5_frame_err", fe_cyc - b_fe, 0);
        check("a5_overrun", ov_cyc - b_ov, 0);
        check("a5_busy_end", {31'd0, busy}, 0);

        // Back-to-back frames at a slow rate
        divisor = 24'd1249;
        snap();
        send_frame(8'hFF, 1'b1, 1250);
        send_frame(8'h00, 1'b1, 1250);
        repeat (20) @(negedge clk);
        check("b2b_count", dv_rises - b_rises, 2);
        check("b2b_byte0", {23'd0, byte_at(b_bytes)}, 32'h0FF);
        check("b2b_byte1", {23'd0, byte_at(b_bytes + 1)}, 32'h000);
        check("b2b_frame_err", fe_cyc - b_fe, 0);
        check("b2b_overrun", ov_cyc - b_ov, 0);

        // One-clock glitch: START for exactly two cycles, then back to IDLE
        divisor = 24'd3;
        snap();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy_cycles", busy_cyc - b_busy, 2);
        check("glitch_count", dv_rises - b_rises, 0);
        check("glitch_frame_err", fe_cyc - b_fe, 0);
        check("glitch_busy_end", {31'd0, busy}, 0);

        // Bad stop bit followed by a long break
        snap();
        send_frame(8'h55, 1'b0, 4);
        repeat (40) @(negedge clk);
        check("brk_busy_low", {31'd0, busy}, 1);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("brk_frame_err", fe_cyc - b_fe, 1);
        check("brk_count", dv_rises - b_rises, 0);
        check("brk_busy_end", {31'd0, busy}, 0);

        // Overrun: second byte completes while first is still held
        data_ready = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1, 4);
        send_frame(8'hC3, 1'b1, 4);
        repeat (20) @(negedge clk);
        check("ovr_count", dv_rises - b_rises, 1);
        check("ovr_byte", {23'd0, byte_at(b_bytes)}, 32'h03C);
        check("ovr_data_out", {24'd0, data_out}, 32'h3C);
        check("ovr_dv_held", {31'd0, data_valid}, 1);
        check("ovr_pulses", ov_cyc - b_ov, 1);
        check("ovr_timing", last_ov - c0, 81);
        data_ready = 1'b1;
        @(negedge clk);
        check("ovr_dv_cleared", {31'd0, data_valid}, 0);
        check("ovr_data_out_kept", {24'd0, data_out}, 32'h3C);

        // Reset mid-frame, then a clean frame
        divisor = 24'd7;
        snap();
        partial = 8'h96;
        drive_bit(1'b0, 8);
        for (int i = 7; i >= 4; i--) drive_bit(partial[i], 8);
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h5A, 1'b1, 8);
        repeat (20) @(negedge clk);
        check("rst_count", dv_rises - b_rises, 1);
        check("rst_byte", {23'd0, byte_at(b_bytes)}, 32'h05A);
        check("rst_frame_err", fe_cyc - b_fe, 0);
        check("rst_overrun", ov_cyc - b_ov, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
